template_result_fifo: RTL

Downstream stage of the template datapath. Consumes the full-precision result stream (output_data / output_data_valid, FULL_SIZE signed, no backpressure), then rounds, shifts and saturates each sample to OUT_SIZE. Samples are buffered in a FIFO and presented to the next consumer over a valid/ready handshake. Overflow and saturation events are counted so that lost or clipped samples can be seen.

---
 rtl/settings_pkg.sv | 42 ++++
 rtl/sync_fifo_fwft.sv | 50 +++++
 rtl/template_result_fifo.sv | 104 ++++++++++
 3 files changed

// File: rtl/settings_pkg.sv
// Shared datapath settings for the template result path.
// Holds sample widths, the result shift and a reference round/saturate helper.
package settings_pkg;

  localparam int FULL_SIZE    = 32;
  localparam int OUT_SIZE     = 16;
  localparam int RESULT_SHIFT = 8;

  typedef logic signed [OUT_SIZE-1:0] out_sample_t;

  typedef struct packed {
    logic        sat;
    out_sample_t value;
  } round_sat_t;

  // Round half toward +inf, arithmetic shift, clamp to OUT_SIZE at package widths.
  function automatic round_sat_t round_sat(input logic signed [FULL_SIZE-1:0] full,
                                           input int unsigned shift);
    logic signed [FULL_SIZE:0] sum;
    logic signed [FULL_SIZE:0] shifted;
    logic signed [FULL_SIZE:0] rnd;
    logic signed [FULL_SIZE:0] max_v;
    logic signed [FULL_SIZE:0] min_v;
    round_sat_t                res;
    rnd     = (shift == 0) ? '0 : ((FULL_SIZE+1)'(1) <<< (shift - 1));
    max_v   = {{(FULL_SIZE-OUT_SIZE+1){1'b0}}, {(OUT_SIZE-1){1'b1}}};
    min_v   = {{(FULL_SIZE-OUT_SIZE+2){1'b1}}, {(OUT_SIZE-1){1'b0}}};
    sum     = $signed({full[FULL_SIZE-1], full}) + rnd;
    shifted = sum >>> shift;
    res.sat = 1'b1;
    if (shifted > max_v) begin
      res.value = max_v[OUT_SIZE-1:0];
    end else if (shifted < min_v) begin
      res.value = min_v[OUT_SIZE-1:0];
    end else begin
      res.value = shifted[OUT_SIZE-1:0];
      res.sat   = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO, registered storage.
// Latency: a word written at edge N is visible at rd_dat in the following cycle.
// Backpressure: wr_acc drops when full unless a read frees a slot in the same cycle.
module sync_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             wr_acc,
  input  logic             rd_rdy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat,
  output logic [AW:0]      fill_level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             rd_en;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en      = rd_rdy && !empty;
  assign wr_acc     = wr_vld && (!full || rd_en);
  assign rd_vld     = !empty;
  assign rd_dat     = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign fill_level = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/template_result_fifo.sv
// Rounds/shifts/saturates the full-precision result stream and buffers it for a consumer.
// Latency: input at cycle N is visible at out_data in cycle N+2 when the FIFO was empty.
// Backpressure: input is never stalled; samples arriving at a full FIFO are dropped and counted.
module template_result_fifo
  import settings_pkg::*;
#(
  parameter int FULL_SIZE = settings_pkg::FULL_SIZE,
  parameter int OUT_SIZE  = settings_pkg::OUT_SIZE,
  parameter int SHIFT     = settings_pkg::RESULT_SHIFT,
  parameter int DEPTH     = 16,
  parameter int CNT_SIZE  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [FULL_SIZE-1:0]       output_data,
  input  logic                       output_data_valid,
  output logic [OUT_SIZE-1:0]        out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       overflow,
  input  logic                       overflow_clear,
  output logic [CNT_SIZE-1:0]        drop_count,
  output logic [CNT_SIZE-1:0]        sat_count
);

  localparam logic signed [FULL_SIZE:0] RND =
    (SHIFT == 0) ? '0 : ((FULL_SIZE+1)'(1) << ((SHIFT == 0) ? 0 : SHIFT - 1));
  localparam logic signed [FULL_SIZE:0] MAX_V =
    {{(FULL_SIZE-OUT_SIZE+1){1'b0}}, {(OUT_SIZE-1){1'b1}}};
  localparam logic signed [FULL_SIZE:0] MIN_V =
    {{(FULL_SIZE-OUT_SIZE+2){1'b1}}, {(OUT_SIZE-1){1'b0}}};

  logic signed [FULL_SIZE:0] sum;
  logic signed [FULL_SIZE:0] shifted;
  logic [OUT_SIZE-1:0]       conv_next;
  logic                      sat_next;

  logic                      conv_vld;
  logic [OUT_SIZE-1:0]       conv_dat;
  logic                      conv_sat;
  logic                      wr_acc;
  logic                      drop_evt;
  logic                      sat_evt;

  // One extra bit of headroom so the rounding add can never wrap.
  always_comb begin
    sum       = $signed({output_data[FULL_SIZE-1], output_data}) + RND;
    shifted   = sum >>> SHIFT;
    conv_next = shifted[OUT_SIZE-1:0];
    sat_next  = 1'b0;
    if (shifted > MAX_V) begin
      conv_next = MAX_V[OUT_SIZE-1:0];
      sat_next  = 1'b1;
    end else if (shifted < MIN_V) begin
      conv_next = MIN_V[OUT_SIZE-1:0];
      sat_next  = 1'b1;
    end
  end

  assign drop_evt = conv_vld && !wr_acc;
  assign sat_evt  = conv_vld && conv_sat;

  // A new event in the same cycle as a clear wins over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      conv_vld   <= 1'b0;
      conv_dat   <= '0;
      conv_sat   <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
      sat_count  <= '0;
    end else begin
      conv_vld <= output_data_valid;
      conv_dat <= conv_next;
      conv_sat <= output_data_valid && sat_next;

      if (drop_evt)            overflow <= 1'b1;
      else if (overflow_clear) overflow <= 1'b0;

      if (overflow_clear)                     drop_count <= CNT_SIZE'(drop_evt);
      else if (drop_evt && drop_count != '1)  drop_count <= drop_count + 1'b1;

      if (overflow_clear)                     sat_count <= CNT_SIZE'(sat_evt);
      else if (sat_evt && sat_count != '1)    sat_count <= sat_count + 1'b1;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (OUT_SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr_vld     (conv_vld),
    .wr_dat     (conv_dat),
    .wr_acc     (wr_acc),
    .rd_rdy     (out_ready),
    .rd_vld     (out_valid),
    .rd_dat     (out_data),
    .fill_level (fill_level)
  );

endmodule
